neuron_input_arbiter: RTL and testbench

- Clocked round-robin arbiter that shares one neuron's input channel (data, req, ack) between N_SRC spike sources.
- Sequences a full four-phase handshake per granted source: data setup, then req high, wait for ack high, req low, wait for ack low.
- Sits in front of a neuron instance, or between neuron layers, when several producers feed one neuron.
- The neuron ack arrives asynchronously and is synchronised inside the block.

---
 rtl/neuron_input_arbiter_pkg.sv | 39 +++
 rtl/neuron_input_arbiter_ack_sync.sv | 31 +++
 rtl/neuron_input_arbiter.sv | 156 +++++++++++++++
 tb/tb_neuron_input_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_input_arbiter_pkg.sv
// Shared types and helpers for the neuron input arbiter: FSM states, round-robin pick.
// Latency: none (combinational helper). Backpressure: not applicable.
package neuron_arb_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_SRC     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        DONE
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } pick_t;

    // First set bit at or above ptr, wrapping at n. Walking offsets downward lets the
    // lowest offset win without an early exit.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 n);
        pick_t res;
        int    cand;
        res = '0;
        for (int off = MAX_SRC - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % n;
            if (off < n && req[cand[3:0]]) begin
                res.vld = 1'b1;
                res.idx = cand[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_input_arbiter_ack_sync.sv
// Multi-flop synchroniser for the neuron's asynchronous acknowledge.
// Latency: STAGES cycles. Backpressure: none, free-running.
module neuron_ack_sync
    import neuron_arb_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/neuron_input_arbiter.sv
// Round-robin arbiter sharing one neuron four-phase channel among N_SRC sources; NEURON_ARB_TIMEOUT_EN adds an ack watchdog.
// Latency: grant one cycle after src_req, nrn_req SETUP_CYC cycles later. Backpressure: sources hold src_req until src_ack.
module neuron_input_arbiter
    import neuron_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [N_SRC-1:0]         src_data,
    output logic [N_SRC-1:0]         src_ack,
    output logic                     nrn_data,
    output logic                     nrn_req,
    input  logic                     nrn_ack,
    output logic                     busy,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int GW = $clog2(N_SRC);

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] src_ack_q, src_ack_d;
    logic             nrn_req_q, nrn_req_d;
    logic             nrn_data_q, nrn_data_d;
    logic [3:0]       setup_cnt_q, setup_cnt_d;
    logic             ack_s;
    logic             tmo_hit;
    pick_t            pick;
    logic [GW-1:0]    pick_idx;

    neuron_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (nrn_ack),
        .sync_out (ack_s)
    );

    assign pick     = rr_pick(MAX_SRC'(src_req), 4'(rr_ptr_q), N_SRC);
    assign pick_idx = GW'(pick.idx);

`ifdef NEURON_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    assign tmo_hit = (state_q == REQ || state_q == RELEASE) && (to_cnt_q == 8'(TIMEOUT_CYC - 1));

    // Counter restarts whenever the FSM moves, so REQ and RELEASE each get the full window.
    always_comb begin
        to_cnt_d      = '0;
        timeout_err_d = timeout_err_q | tmo_hit;
        if ((state_q == REQ || state_q == RELEASE) && state_d == state_q) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        src_ack_d   = '0;
        nrn_req_d   = nrn_req_q;
        nrn_data_d  = nrn_data_q;
        setup_cnt_d = setup_cnt_q;
        case (state_q)
            IDLE: begin
                // A still-high ack belongs to the previous handshake; never start on top of it.
                if (pick.vld && !ack_s) begin
                    grant_d     = pick_idx;
                    nrn_data_d  = src_data[pick_idx];
                    setup_cnt_d = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == 4'(SETUP_CYC - 1)) begin
                    nrn_req_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    setup_cnt_d = setup_cnt_q + 4'd1;
                end
            end
            REQ: begin
                if (tmo_hit) begin
                    nrn_req_d          = 1'b0;
                    nrn_data_d         = 1'b0;
                    src_ack_d[grant_q] = 1'b1;
                    state_d            = DONE;
                end else if (ack_s) begin
                    nrn_req_d = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (tmo_hit || !ack_s) begin
                    nrn_data_d         = 1'b0;
                    src_ack_d[grant_q] = 1'b1;
                    state_d            = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + GW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            src_ack_q   <= '0;
            nrn_req_q   <= 1'b0;
            nrn_data_q  <= 1'b0;
            setup_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            src_ack_q   <= src_ack_d;
            nrn_req_q   <= nrn_req_d;
            nrn_data_q  <= nrn_data_d;
            setup_cnt_q <= setup_cnt_d;
        end
    end

    assign src_ack  = src_ack_q;
    assign nrn_req  = nrn_req_q;
    assign nrn_data = nrn_data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_input_arbiter.sv
// Self-checking bench for neuron_input_arbiter with a behavioural neuron responder and arbitration model.
module tb_neuron_input_arbiter;

    localparam int N         = 4;
    localparam int SETUP_CYC = 1;
`ifdef NEURON_ARB_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_req;
    logic [N-1:0] src_data;
    logic [N-1:0] src_ack;
    logic         nrn_data;
    logic         nrn_req;
    logic         nrn_ack;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout_err;

    logic resp_ack  = 1'b0;
    logic force_en  = 1'b0;
    logic force_val = 1'b0;
    int   rise_dly  = 2;
    int   fall_dly  = 2;
    int   resp_cnt  = 0;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int model_ptr = 0;

    assign nrn_ack = force_en ? force_val : resp_ack;

    always #5 clk = ~clk;

    neuron_input_arbiter #(
        .N_SRC       (N),
        .SETUP_CYC   (SETUP_CYC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .nrn_data    (nrn_data),
        .nrn_req     (nrn_req),
        .nrn_ack     (nrn_ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // Neuron: raise ack rise_dly cycles after seeing req, drop it fall_dly cycles after req falls.
    always @(negedge clk) begin
        if (rst) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
        end else if (nrn_req && !resp_ack) begin
            resp_cnt++;
            if (resp_cnt >= rise_dly) begin
                resp_ack = 1'b1;
                resp_cnt = 0;
            end
        end else if (!nrn_req && resp_ack) begin
            resp_cnt++;
            if (resp_cnt >= fall_dly) begin
                resp_ack = 1'b0;
                resp_cnt = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // Reference: first requester at or after ptr, wrapping around.
    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One complete transaction checked against the model.
    task automatic do_txn(input bit drop_at_grant, input logic [N-1:0] blip, input bit rereq);
        int           exp_idx;
        int           cyc;
        int           ack_cycles;
        bit           granted;
        bit           finished;
        bit           data_bad;
        logic         exp_data;
        logic [N-1:0] ack_val;
        logic [N-1:0] exp_ack;
        rise_dly   = $urandom_range(1, 4);
        fall_dly   = $urandom_range(1, 4);
        granted    = 1'b0;
        finished   = 1'b0;
        data_bad   = 1'b0;
        ack_cycles = 0;
        ack_val    = '0;
        for (int c = 0; c < 40 && !granted; c++) begin
            @(negedge clk);
            if (busy) granted = 1'b1;
        end
        total_cnt++;
        if (!granted) begin
            $display("FAIL grant_wait: busy=%0b after 40 cycles, required 1", busy);
            return;
        end
        pass_cnt++;
        exp_idx = ref_pick(src_req, model_ptr);
        if (exp_idx < 0) exp_idx = 0;
        exp_data = src_data[exp_idx];
        exp_ack  = '0;
        exp_ack[exp_idx] = 1'b1;
        total_cnt++;
        if (grant_id !== 2'(exp_idx)) $display("FAIL grant_id: got %0d, required %0d", grant_id, exp_idx);
        else pass_cnt++;
        total_cnt++;
        if (nrn_data !== exp_data) $display("FAIL grant_data: got %0b, required %0b", nrn_data, exp_data);
        else pass_cnt++;
        if (drop_at_grant) src_req[exp_idx] = 1'b0;
        cyc = 0;
        while (cyc < 80 && !finished) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) src_req = src_req | blip;
            if (cyc == 3) src_req = src_req & ~blip;
            if (src_ack != '0) begin
                ack_cycles++;
                ack_val = src_ack;
                if (!rereq) src_req[exp_idx] = 1'b0;
            end else if (busy && nrn_data !== exp_data) begin
                data_bad = 1'b1;
            end
            if (ack_cycles > 0 && !busy) finished = 1'b1;
        end
        total_cnt++;
        if (!finished) $display("FAIL txn_end: no return to idle within 80 cycles, busy=%0b", busy);
        else pass_cnt++;
        total_cnt++;
        if (ack_cycles != 1 || ack_val !== exp_ack)
            $display("FAIL src_ack: got %b for %0d cycles, required %b for 1 cycle", ack_val, ack_cycles, exp_ack);
        else pass_cnt++;
        total_cnt++;
        if (data_bad) $display("FAIL data_hold: nrn_data changed mid-transaction, required %0b", exp_data);
        else pass_cnt++;
        model_ptr = (exp_idx + 1) % N;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        src_req  = '0;
        src_data = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %0b, required 0", busy); else pass_cnt++;
        total_cnt++;
        if (nrn_req !== 1'b0) $display("FAIL rst_req: got %0b, required 0", nrn_req); else pass_cnt++;
        total_cnt++;
        if (nrn_data !== 1'b0) $display("FAIL rst_data: got %0b, required 0", nrn_data); else pass_cnt++;
        total_cnt++;
        if (src_ack !== '0) $display("FAIL rst_ack: got %b, required 0", src_ack); else pass_cnt++;
        total_cnt++;
        if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d, required 0", grant_id); else pass_cnt++;
        total_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL rst_tmo: got %0b, required 0", timeout_err); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        model_ptr = 0;
    endtask

    task automatic test_round_robin();
        src_req = '1;
        for (int t = 0; t < 5; t++) begin
            src_data = 4'($urandom);
            do_txn(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_single();
        int   acks;
        bit   done;
        bit   bad_data;
        logic [N-1:0] ack_val;
        src_data = 4'b0100;
        src_req  = 4'b0100;
        rise_dly = 3;
        fall_dly = 1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || grant_id !== 2'd2)
            $display("FAIL single_grant: busy=%0b grant=%0d, required busy=1 grant=2", busy, grant_id);
        else pass_cnt++;
        total_cnt++;
        if (nrn_data !== 1'b1 || nrn_req !== 1'b0)
            $display("FAIL single_setup: data=%0b req=%0b, required data=1 req=0", nrn_data, nrn_req);
        else pass_cnt++;
        repeat (SETUP_CYC) @(negedge clk);
        total_cnt++;
        if (nrn_req !== 1'b1) $display("FAIL single_req_latency: got %0b, required 1", nrn_req);
        else pass_cnt++;
        acks = 0; done = 1'b0; bad_data = 1'b0; ack_val = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (nrn_req && nrn_data !== 1'b1) bad_data = 1'b1;
            if (src_ack != '0) begin
                acks++;
                ack_val = src_ack;
                src_req = '0;
                if (nrn_data !== 1'b0) bad_data = 1'b1;
            end
            if (acks > 0 && !busy) done = 1'b1;
        end
        total_cnt++;
        if (acks != 1 || ack_val !== 4'b0100)
            $display("FAIL single_ack: got %b for %0d cycles, required 0100 for 1 cycle", ack_val, acks);
        else pass_cnt++;
        total_cnt++;
        if (bad_data || !done) $display("FAIL single_data: bad=%0b done=%0b, required bad=0 done=1", bad_data, done);
        else pass_cnt++;
        model_ptr = 3;
        // With every source asking, the pointer left at 3 must pick source 3.
        src_req = '1;
        do_txn(1'b0, '0, 1'b0);
        src_req = '0;
    endtask

    task automatic test_withdraw();
        bit stray;
        src_req = 4'b0010;
        do_txn(1'b1, 4'b1000, 1'b0);
        stray = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) stray = 1'b1;
        end
        total_cnt++;
        if (stray) $display("FAIL withdraw_idle: busy=1 seen, required 0 (grant_id=%0d)", grant_id);
        else pass_cnt++;
    endtask

    task automatic test_ack_held();
        bit idle_ok;
        force_val = 1'b1;
        force_en  = 1'b1;
        repeat (3) @(negedge clk);
        src_req = 4'b0001;
        idle_ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy) idle_ok = 1'b0;
        end
        total_cnt++;
        if (!idle_ok) $display("FAIL ack_held_grant: busy=1 seen, required 0");
        else pass_cnt++;
        force_val = 1'b0;
        force_en  = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL ack_sync_delay: busy=%0b, required 0", busy);
        else pass_cnt++;
        do_txn(1'b0, '0, 1'b0);
        src_req = '0;
    endtask

    task automatic test_mid_reset();
        bit in_req;
        src_req = 4'b1110;
        rise_dly = 50;
        in_req = 1'b0;
        for (int c = 0; c < 40 && !in_req; c++) begin
            @(negedge clk);
            if (nrn_req) in_req = 1'b1;
        end
        total_cnt++;
        if (!in_req) $display("FAIL mid_rst_reach_req: nrn_req=%0b, required 1", nrn_req);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (nrn_req !== 1'b0 || busy !== 1'b0 || src_ack !== '0)
            $display("FAIL mid_rst: req=%0b busy=%0b ack=%b, required 0 0 0000", nrn_req, busy, src_ack);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        src_req = '1;
        do_txn(1'b0, '0, 1'b0);
        src_req = '0;
    endtask

`ifdef NEURON_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   req_cycles;
        bit   got_ack;
        bit   granted;
        logic [N-1:0] ack_val;
        logic err_at_ack;
        bit   sticky;
        @(negedge clk);
        src_req  = 4'b0100;
        rise_dly = 100000;
        granted  = 1'b0;
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            if (busy) granted = 1'b1;
        end
        req_cycles = 0; got_ack = 1'b0; ack_val = '0; err_at_ack = 1'b0;
        for (int c = 0; c < 60 && !got_ack; c++) begin
            @(negedge clk);
            if (nrn_req) req_cycles++;
            if (src_ack != '0) begin
                got_ack    = 1'b1;
                ack_val    = src_ack;
                err_at_ack = timeout_err;
                src_req    = '0;
            end
        end
        total_cnt++;
        if (!granted || !got_ack || ack_val !== 4'b0100)
            $display("FAIL tmo_ack: granted=%0b ack=%b, required 1 and 0100", granted, ack_val);
        else pass_cnt++;
        total_cnt++;
        if (req_cycles != TMO) $display("FAIL tmo_req_cycles: got %0d, required %0d", req_cycles, TMO);
        else pass_cnt++;
        total_cnt++;
        if (err_at_ack !== 1'b1) $display("FAIL tmo_flag: got %0b, required 1", err_at_ack);
        else pass_cnt++;
        sticky = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (timeout_err !== 1'b1 || busy !== 1'b0) sticky = 1'b0;
        end
        total_cnt++;
        if (!sticky) $display("FAIL tmo_sticky: err=%0b busy=%0b, required 1 0", timeout_err, busy);
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL tmo_clear: got %0b, required 0", timeout_err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_withdraw();
        test_ack_held();
        test_mid_reset();
`ifdef NEURON_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
